lfsr_hexdisp: RTL and testbench

LFSR_HEXDISP -- requirements
Module: lfsr_hexdisp

---
 rtl/lfsr_hexdisp.sv | 125 ++++++++++++
 tb/tb_lfsr_hexdisp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_hexdisp.sv
// lfsr_hexdisp: right-shifting Fibonacci LFSR with a free-run prescaler,
// single-step control, sequence-length measurement and an active-low
// seven-segment hex view of the current state.
module lfsr_hexdisp #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter int               DIV        = 1,
  localparam int              DIGITS     = (WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      seed,
  input  logic                  run_en,
  input  logic                  step,
  output logic [WIDTH-1:0]      state,
  output logic [8*DIGITS-1:0]   hex,
  output logic [WIDTH-1:0]      period,
  output logic                  period_valid,
  output logic                  wrap
);

  // Prescaler only needs to hold 0..DIV-1; keep at least one bit for DIV=1.
  localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] seed_eff;
  logic             fb;
  logic             tick;
  logic             adv;
  logic [4*DIGITS-1:0] padded;

  // Saturating increment: the all-ones value is sticky.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == '1) ? v : v + WIDTH'(1);
  endfunction

  // Active-high segment pattern {a,b,c,d,e,f,g,dp}, dp never lit.
  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    return 8'hFC;
      4'h1:    return 8'h60;
      4'h2:    return 8'hDA;
      4'h3:    return 8'hF2;
      4'h4:    return 8'h66;
      4'h5:    return 8'hB6;
      4'h6:    return 8'hBE;
      4'h7:    return 8'hE0;
      4'h8:    return 8'hFE;
      4'h9:    return 8'hF6;
      4'hA:    return 8'hEE;
      4'hB:    return 8'h3E;
      4'hC:    return 8'h9C;
      4'hD:    return 8'h7A;
      4'hE:    return 8'h9E;
      default: return 8'h8E;
    endcase
  endfunction

  // Advance request, feedback and the zero-safe seed.
  always_comb begin
    tick     = run_en && (presc == PRE_MAX);
    adv      = step || tick;
    fb       = ^(state & TAPS);
    nxt      = {fb, state[WIDTH-1:1]};
    seed_eff = (seed == '0) ? WIDTH'(1) : seed;
  end

  // Prescaler: counts while run_en is high, freezes otherwise, cleared by rst/load.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      presc <= '0;
    end else if (run_en) begin
      presc <= (presc == PRE_MAX) ? '0 : presc + PW'(1);
    end
  end

  // LFSR state, start marker, advance counter and period capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RESET_SEED;
      start        <= RESET_SEED;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      wrap         <= 1'b0;
    end else if (load) begin
      state        <= seed_eff;
      start        <= seed_eff;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (adv) begin
        state <= nxt;
        cnt   <= sat_inc(cnt);
        if (nxt == start) begin
          wrap <= 1'b1;
          if (!period_valid) begin
            period       <= sat_inc(cnt);
            period_valid <= 1'b1;
          end
        end
      end
    end
  end

  // Hex view: one inverted segment byte per nibble, upper pad bits read as 0.
  always_comb begin
    padded            = '0;
    padded[WIDTH-1:0] = state;
    hex               = '0;
    for (int k = 0; k < DIGITS; k++) begin
      hex[8*k +: 8] = ~seg7(padded[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_lfsr_hexdisp.sv
// tb_lfsr_hexdisp: table vectors and scoreboard-driven sequences for the
// default 8-bit LFSR, a DIV=4 prescaled instance and a 16-bit instance.
module tb_lfsr_hexdisp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults, DIV=1
  logic        a_rst = 0, a_load = 0, a_run = 0, a_step = 0;
  logic [7:0]  a_seed = 0;
  logic [7:0]  a_state, a_period;
  logic [15:0] a_hex;
  logic        a_pv, a_wrap;

  // Instance B: DIV=4
  logic        b_rst = 0, b_load = 0, b_run = 0, b_step = 0;
  logic [7:0]  b_seed = 0;
  logic [7:0]  b_state, b_period;
  logic [15:0] b_hex;
  logic        b_pv, b_wrap;

  // Instance C: 16-bit
  logic        c_rst = 0, c_load = 0, c_run = 0, c_step = 0;
  logic [15:0] c_seed = 0;
  logic [15:0] c_state, c_period;
  logic [31:0] c_hex;
  logic        c_pv, c_wrap;

  lfsr_hexdisp dut_a (
    .clk(clk), .rst(a_rst), .load(a_load), .seed(a_seed), .run_en(a_run),
    .step(a_step), .state(a_state), .hex(a_hex), .period(a_period),
    .period_valid(a_pv), .wrap(a_wrap));

  lfsr_hexdisp #(.DIV(4)) dut_b (
    .clk(clk), .rst(b_rst), .load(b_load), .seed(b_seed), .run_en(b_run),
    .step(b_step), .state(b_state), .hex(b_hex), .period(b_period),
    .period_valid(b_pv), .wrap(b_wrap));

  lfsr_hexdisp #(.WIDTH(16), .TAPS(16'h002D), .RESET_SEED(16'h0001)) dut_c (
    .clk(clk), .rst(c_rst), .load(c_load), .seed(c_seed), .run_en(c_run),
    .step(c_step), .state(c_state), .hex(c_hex), .period(c_period),
    .period_valid(c_pv), .wrap(c_wrap));

  typedef struct {
    int          dut;
    int          tag;
    logic [31:0] st;
    logic        chk_hx;
    logic [31:0] hx;
    logic        chk_wr;
    logic        wr;
    logic        chk_per;
    logic [31:0] per;
    logic        pv;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        load;
    logic [7:0]  seed;
    logic        run;
    logic        step;
    logic [7:0]  st;
    logic [15:0] hx;
  } vec_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  logic [7:0] m_a;
  logic [7:0] m_b;

  function automatic logic [7:0] nxt8(input logic [7:0] s);
    logic f;
    f = s[0] ^ s[2] ^ s[3] ^ s[4];
    return {f, s[7:1]};
  endfunction

  function automatic exp_t mk(input int dut, input int tag, input logic [31:0] st,
                              input logic chk_hx, input logic [31:0] hx,
                              input logic chk_wr, input logic wr,
                              input logic chk_per, input logic [31:0] per, input logic pv);
    exp_t e;
    e.dut = dut; e.tag = tag; e.st = st; e.chk_hx = chk_hx; e.hx = hx;
    e.chk_wr = chk_wr; e.wr = wr; e.chk_per = chk_per; e.per = per; e.pv = pv;
    return e;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0h, expected %0h", nm, tag, act, exp);
  endtask

  // Advance one clock and compare the oldest scoreboard entry with the DUT.
  task automatic settle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    case (e.dut)
      0: begin
        chk("a_state", e.tag, {24'h0, a_state}, e.st);
        if (e.chk_hx)  chk("a_hex", e.tag, {16'h0, a_hex}, e.hx);
        if (e.chk_wr)  chk("a_wrap", e.tag, {31'h0, a_wrap}, {31'h0, e.wr});
        if (e.chk_per) begin
          chk("a_period", e.tag, {24'h0, a_period}, e.per);
          chk("a_period_valid", e.tag, {31'h0, a_pv}, {31'h0, e.pv});
        end
      end
      1: begin
        chk("b_state", e.tag, {24'h0, b_state}, e.st);
        if (e.chk_hx)  chk("b_hex", e.tag, {16'h0, b_hex}, e.hx);
      end
      default: begin
        chk("c_state", e.tag, {16'h0, c_state}, e.st);
        if (e.chk_hx)  chk("c_hex", e.tag, c_hex, e.hx);
        if (e.chk_per) begin
          chk("c_period", e.tag, {16'h0, c_period}, e.per);
          chk("c_period_valid", e.tag, {31'h0, c_pv}, {31'h0, e.pv});
        end
      end
    endcase
  endtask

  // Free-run A for n cycles from a fresh measurement started at seed 0x01.
  task automatic run_a(input int n, input int tag);
    a_rst = 0; a_load = 0; a_step = 0; a_run = 1;
    for (int i = 1; i <= n; i++) begin
      m_a = nxt8(m_a);
      sb.push_back(mk(0, tag + i, {24'h0, m_a}, 1'b0, 32'h0, 1'b1, (i % 255) == 0,
                      1'b1, (i >= 255) ? 32'd255 : 32'd0, i >= 255));
      settle();
    end
    a_run = 0;
  endtask

  task automatic cyc_b(input logic r, input logic l, input logic [7:0] sd,
                       input logic rn, input logic sp, input logic [7:0] st, input int tag);
    b_rst = r; b_load = l; b_seed = sd; b_run = rn; b_step = sp;
    sb.push_back(mk(1, tag, {24'h0, st}, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0));
    settle();
  endtask

  vec_t tbl[8];
  int   n;

  initial begin
    // rst, step, load corner cases on A
    tbl[0] = '{rst:1, load:0, seed:8'h00, run:0, step:0, st:8'h01, hx:16'h039F};
    tbl[1] = '{rst:0, load:0, seed:8'h00, run:0, step:1, st:8'h80, hx:16'h0103};
    tbl[2] = '{rst:0, load:0, seed:8'h00, run:0, step:1, st:8'h40, hx:16'h9903};
    tbl[3] = '{rst:0, load:1, seed:8'h00, run:0, step:0, st:8'h01, hx:16'h039F};
    tbl[4] = '{rst:0, load:1, seed:8'hA5, run:0, step:0, st:8'hA5, hx:16'h1149};
    tbl[5] = '{rst:0, load:1, seed:8'h01, run:0, step:1, st:8'h01, hx:16'h039F};
    tbl[6] = '{rst:0, load:0, seed:8'h00, run:1, step:1, st:8'h80, hx:16'h0103};
    tbl[7] = '{rst:0, load:0, seed:8'h00, run:0, step:0, st:8'h80, hx:16'h0103};

    for (int i = 0; i < 8; i++) begin
      a_rst = tbl[i].rst; a_load = tbl[i].load; a_seed = tbl[i].seed;
      a_run = tbl[i].run; a_step = tbl[i].step;
      sb.push_back(mk(0, i, {24'h0, tbl[i].st}, 1'b1, {16'h0, tbl[i].hx},
                      1'b1, 1'b0, 1'b1, 32'h0, 1'b0));
      settle();
    end

    // Full period measurement on A: wrap at 255 and 510, period 255
    a_run = 0; a_step = 0; a_load = 1; a_seed = 8'h01;
    sb.push_back(mk(0, 100, 32'h01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0));
    settle();
    m_a = 8'h01;
    run_a(510, 1000);

    // rst in the middle of a measurement discards it
    a_load = 1; a_seed = 8'h01;
    sb.push_back(mk(0, 200, 32'h01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0));
    settle();
    m_a = 8'h01;
    run_a(100, 2000);
    a_rst = 1;
    sb.push_back(mk(0, 300, 32'h01, 1'b1, 32'h039F, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0));
    settle();
    m_a = 8'h01;
    run_a(255, 3000);

    // B: prescaler pacing, freeze, load during run, step with tick
    m_b = 8'h01;
    cyc_b(1, 0, 8'h00, 0, 0, m_b, 0);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 1);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 2);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 3);
    m_b = nxt8(m_b);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 4);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 5);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 6);
    for (int i = 0; i < 3; i++) cyc_b(0, 0, 8'h00, 0, 0, m_b, 7 + i);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 10);
    m_b = nxt8(m_b);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 11);
    m_b = 8'h33;
    cyc_b(0, 1, 8'h33, 1, 0, m_b, 12);
    for (int i = 0; i < 3; i++) cyc_b(0, 0, 8'h00, 1, 0, m_b, 13 + i);
    m_b = nxt8(m_b);
    cyc_b(0, 0, 8'h00, 1, 0, m_b, 16);
    m_b = nxt8(m_b);
    cyc_b(0, 0, 8'h00, 0, 1, m_b, 17);
    for (int i = 0; i < 3; i++) cyc_b(0, 0, 8'h00, 1, 0, m_b, 18 + i);
    m_b = nxt8(m_b);
    cyc_b(0, 0, 8'h00, 1, 1, m_b, 21);
    cyc_b(0, 0, 8'h00, 0, 0, m_b, 22);

    // C: 16-bit reset view and full-length period
    c_rst = 1;
    sb.push_back(mk(2, 0, 32'h0001, 1'b1, 32'h0303039F, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0));
    settle();
    c_rst = 0; c_run = 1;
    n = 0;
    while (!c_pv && n < 70000) begin
      @(posedge clk);
      #1;
      n++;
    end
    c_run = 0;
    chk("c_cycles_to_valid", 0, n, 32'd65535);
    chk("c_period", 1, {16'h0, c_period}, 32'd65535);
    chk("c_wrap", 2, {31'h0, c_wrap}, 32'd1);
    chk("c_state_at_wrap", 3, {16'h0, c_state}, 32'h0001);
    chk("c_hex_at_wrap", 4, c_hex, 32'h0303039F);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
